axrm_seq_divider: RTL

Iterative restoring divider that inverts the 8x8 approximate recursive multipliers. It takes a 2N-bit product and an N-bit operand and recovers the other operand plus a remainder. The error-characterisation flow uses it to back-solve operands from exact or approximate products. It is multi-cycle, with one quotient bit per clock, and uses valid/ready handshakes on both input and output.

---
 rtl/axrm_seq_divider.sv | 110 +++++++++++
 1 files changed

// File: rtl/axrm_seq_divider.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Used to back-solve multiplier operands from exact or approximate products.
module axrm_seq_divider #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero,
    output logic             q_ovf
);

    localparam int unsigned CW = $clog2(2 * N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q;
    logic [2*N-1:0]   work_q, work_d;
    logic [N-1:0]     part_q, part_d;
    logic [N-1:0]     dvsr_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic [2*N-1:0]   quotient_q;
    logic [N-1:0]     remainder_q;
    logic             dbz_q;
    logic             ovf_q;

    logic [N:0]       trial;
    logic [N:0]       diff;
    logic             ge;

    // partial < divisor keeps trial < 2*divisor, so diff[N] is a clean borrow flag.
    always_comb begin
        trial  = {part_q, work_q[2*N-1]};
        diff   = trial - {1'b0, dvsr_q};
        ge     = ~diff[N];
        part_d = ge ? diff[N-1:0] : trial[N-1:0];
        work_d = {work_q[2*N-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            work_q      <= '0;
            part_q      <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= dividend;
                        dvsr_q  <= divisor;
                        part_q  <= '0;
                        zero_q  <= (divisor == '0);
                        cnt_q   <= CW'(2 * N - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // A zero divisor spends a single cycle here so its result lands one edge after acceptance.
                    if (zero_q) begin
                        quotient_q  <= '1;
                        remainder_q <= work_q[N-1:0];
                        dbz_q       <= 1'b1;
                        ovf_q       <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        work_q <= work_d;
                        part_q <= part_d;
                        cnt_q  <= cnt_q - CW'(1);
                        if (cnt_q == '0) begin
                            quotient_q  <= work_d;
                            remainder_q <= part_d;
                            dbz_q       <= 1'b0;
                            ovf_q       <= |work_d[2*N-1:N];
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign q_ovf       = ovf_q;

endmodule
